multicycle_ctrl: RTL

- Sequencing controller for the execute datapath in a multi-cycle LEGv8 core (ALU, branch adder, ALU-source mux).
- One shared memory port serves both instruction fetch and data access.
- The controller steps each instruction through fetch, decode, execute, memory and writeback.
- It drives AluSrc/AluControl for the execute stage, the PC/IR/register-file/memory strobes, a memory-ack watchdog and a retired-instruction counter.

---
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Controller-to-datapath bundle for the multi-cycle LEGv8 sequencer.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [10:0]      op;
    logic             zero;
    logic             memAck;
    logic             irWrite;
    logic             pcWrite;
    logic             pcSrc;
    logic             AluSrc;
    logic [3:0]       AluControl;
    logic             memRead;
    logic             memWrite;
    logic             memAddrSrc;
    logic             regWrite;
    logic             memToReg;
    logic             instrDone;
    logic             err;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state;

    // Controller side
    modport master (
        input  op, zero, memAck,
        output irWrite, pcWrite, pcSrc, AluSrc, AluControl, memRead, memWrite,
               memAddrSrc, regWrite, memToReg, instrDone, err, retired, state
    );

    // Datapath / memory side
    modport slave (
        output op, zero, memAck,
        input  irWrite, pcWrite, pcSrc, AluSrc, AluControl, memRead, memWrite,
               memAddrSrc, regWrite, memToReg, instrDone, err, retired, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 sequencing controller: fetch/decode/exec/mem/wb with
// shared memory port, memory-ack watchdog and retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    localparam int unsigned     WD_W    = 16;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_ADD, C_SUB, C_AND, C_ORR, C_LDUR, C_STUR, C_CBZ, C_B
    } cls_t;

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d, dec_cls;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0] ret_q;
    logic             retire;
    logic             ir_write, pc_write, pc_src, alu_src;
    logic [3:0]       alu_ctl;
    logic             mem_read, mem_write, mem_addr_src;
    logic             reg_write, mem_to_reg, in_err;

    // Opcode classifier; anything unrecognised maps to C_NONE
    always_comb begin
        dec_cls = C_NONE;
        if      (bus.op == 11'h458)        dec_cls = C_ADD;
        else if (bus.op == 11'h658)        dec_cls = C_SUB;
        else if (bus.op == 11'h450)        dec_cls = C_AND;
        else if (bus.op == 11'h550)        dec_cls = C_ORR;
        else if (bus.op == 11'h7C2)        dec_cls = C_LDUR;
        else if (bus.op == 11'h7C0)        dec_cls = C_STUR;
        else if (bus.op[10:3] == 8'hB4)    dec_cls = C_CBZ;
        else if (bus.op[10:5] == 6'h05)    dec_cls = C_B;
    end

    // State, class, watchdog and retire-count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= C_NONE;
            wd_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wd_q    <= wd_d;
            if (retire) ret_q <= ret_q + CNT_W'(1);
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        wd_d         = wd_q;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_src      = 1'b0;
        alu_ctl      = ALU_AND;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_src = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        retire       = 1'b0;
        in_err       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (bus.memAck) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_DECODE: begin
                cls_d   = dec_cls;
                state_d = (dec_cls == C_NONE) ? S_ERR : S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_ADD: begin alu_ctl = ALU_ADD; state_d = S_WB; end
                    C_SUB: begin alu_ctl = ALU_SUB; state_d = S_WB; end
                    C_AND: begin alu_ctl = ALU_AND; state_d = S_WB; end
                    C_ORR: begin alu_ctl = ALU_ORR; state_d = S_WB; end
                    C_LDUR, C_STUR: begin
                        alu_src = 1'b1;
                        alu_ctl = ALU_ADD;
                        state_d = S_MEM;
                    end
                    C_CBZ: begin
                        alu_ctl  = ALU_PASSB;
                        pc_write = bus.zero;
                        pc_src   = bus.zero;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_ERR;
                endcase
            end
            S_MEM: begin
                // Hold the address computation stable for the whole access
                alu_src      = 1'b1;
                alu_ctl      = ALU_ADD;
                mem_addr_src = 1'b1;
                mem_read     = (cls_q == C_LDUR);
                mem_write    = (cls_q == C_STUR);
                if (bus.memAck) begin
                    if (cls_q == C_LDUR) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LDUR);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ERR: begin
                in_err = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        if (state_d != state_q) wd_d = '0;
    end

    // All outputs held low while reset is asserted
    assign bus.irWrite    = ir_write     & ~reset;
    assign bus.pcWrite    = pc_write     & ~reset;
    assign bus.pcSrc      = pc_src       & ~reset;
    assign bus.AluSrc     = alu_src      & ~reset;
    assign bus.AluControl = reset ? 4'b0000 : alu_ctl;
    assign bus.memRead    = mem_read     & ~reset;
    assign bus.memWrite   = mem_write    & ~reset;
    assign bus.memAddrSrc = mem_addr_src & ~reset;
    assign bus.regWrite   = reg_write    & ~reset;
    assign bus.memToReg   = mem_to_reg   & ~reset;
    assign bus.instrDone  = retire       & ~reset;
    assign bus.err        = in_err       & ~reset;
    assign bus.retired    = reset ? '0 : ret_q;
    assign bus.state      = reset ? 3'd0 : 3'(state_q);
endmodule
